pop_stream_monitor: RTL and testbench
=====================================

// Module: pop_stream_monitor
// PURPOSE
//  Downstream consumer of the 8-bit popped-value stream produced by the queue stage.
//  - Captures each popped byte into a bounded circular history FIFO.
//  - Counts pops, and checks each byte against an expected value.
//  - Exposes the history through a valid/ready read port for the bench or a debug host.
// PARAMETERS
//  DEPTH      16     history FIFO entries; power of 2, >=2
//  EXP_VAL    8'h08  expected popped value
//  CNT_W      16     width of pop_count and mismatch_count
//  FREEZE_ERR 1      1: stop capturing after the first mismatch (FROZEN state)
// PORTS
//  clk            in   1              rising-edge clock
//  reset_n        in   1              async active-low reset
//  enable         in   1              IDLE->RUN request
//  clear          in   1              sync clear: FIFO, counters, error flag; -> IDLE
//  pop_valid      in   1              one pop per cycle when high
//  pop_data       in   8              popped byte, sampled when pop_valid=1
//  hist_valid     out  1              hist_data holds the oldest entry
//  hist_ready     in   1              consumer accepts hist_data
//  hist_data      out  8              oldest captured byte (8'h00 when empty)
//  level          out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
//  full           out  1              level==DEPTH
//  overflow       out  1              sticky: capture dropped because FIFO full
//  pop_count      out  CNT_W          pops accepted in RUN, saturating
//  mismatch_count out  CNT_W          accepted pops with pop_data!=EXP_VAL, saturating
//  err_sticky     out  1              set on first mismatch
//  state          out  2              00 IDLE, 01 RUN, 10 FROZEN
// BEHAVIOUR
//  Reset: every output is 0 and state=IDLE; FIFO pointers are 0.
//  State machine (clear has priority over all transitions):
//   - IDLE -> RUN when enable=1.
//   - RUN -> IDLE when enable=0.
//   - RUN -> FROZEN on a mismatch if FREEZE_ERR=1.
//   - FROZEN -> IDLE on clear only.
//  Capture (RUN only):
//   - A pop is accepted when pop_valid=1; pop_valid is ignored in IDLE and FROZEN.
//   - Write latency 1: hist_valid rises the cycle after a capture into an empty FIFO.
//   - The mismatching pop itself is captured and counted before entering FROZEN.
//   - Full and no read in the same cycle: byte dropped, overflow<=1.
//     pop_count and the mismatch check still apply to the dropped byte.
//  Read port:
//   - Pop the FIFO on hist_valid && hist_ready.
//   - hist_valid = (level!=0); hist_data is driven from the read pointer with no extra latency.
//   - Reads stay allowed in every state.
//  Simultaneous write and read:
//   - When full: both occur and level is unchanged (no overflow).
//   - When empty: the write occurs; the read is not performed.
//  Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH; level is tracked separately.
//  Counters: saturate at all-ones and never wrap; err_sticky and overflow clear only on clear or reset.
//  Reset mid-operation: immediate return to reset values; the FIFO content is discarded.
// CONFIGURATION
//  POP_MON_MINMAX_EN defined:
//   - Adds outputs min_val[7:0] (reset 8'hFF) and max_val[7:0] (reset 8'h00).
//   - Both update on every accepted pop, including dropped ones.
//   - Both return to their reset values on clear.
//  POP_MON_MINMAX_EN undefined: these ports and their registers do not exist.
// TESTING
//  T1 reset: reset_n=0 mid-RUN with level=5 -> next edge all outputs 0, state=IDLE.
//  T2 normal: enable=1, 4 pops of 8'h08, hist_ready=0 -> level=4, pop_count=4, mismatch_count=0;
//     then hist_ready=1 -> drains 08,08,08,08 and hist_valid falls after the 4th.
//  T3 mismatch: FREEZE_ERR=1, pops 08,08,3C,08 -> pop_count=3, mismatch_count=1, err_sticky=1,
//     state=FROZEN, 4th pop ignored; clear -> IDLE with counters 0.
//  T4 full: DEPTH=16, 17 pops with no reads -> level=16, full=1, overflow=1, pop_count=17;
//     17th pop with hist_ready=1 -> no overflow, level stays 16.
//  T5 wrap: 40 pops of values 0..39 interleaved with reads -> bytes read out in order 0..39.
//  T6 minmax (POP_MON_MINMAX_EN): pops 08,02,F0 -> min_val=02, max_val=F0; clear -> FF/00.

Source files
------------

// File: rtl/pop_stream_monitor_if.sv
// Popped-byte stream and history read port of pop_stream_monitor.
// master: producer/consumer side; slave: the monitor.
interface pop_stream_monitor_if;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic       hist_valid;
    logic       hist_ready;
    logic [7:0] hist_data;

    modport master (output pop_valid, pop_data, hist_ready, input hist_valid, hist_data);
    modport slave  (input pop_valid, pop_data, hist_ready, output hist_valid, hist_data);
endinterface

// File: rtl/pop_stream_monitor.sv
// Captures popped bytes into a circular history FIFO, counts pops and value mismatches.
// Optional POP_MON_MINMAX_EN adds running min/max of accepted pops.
module pop_stream_monitor #(
    parameter int unsigned Depth     = 16,
    parameter logic [7:0]  ExpVal    = 8'h08,
    parameter int unsigned CntW      = 16,
    parameter bit          FreezeErr = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    clear_i,
    pop_stream_monitor_if.slave     bus,
    output logic [$clog2(Depth):0]  level_o,
    output logic                    full_o,
    output logic                    overflow_o,
    output logic [CntW-1:0]         pop_count_o,
    output logic [CntW-1:0]         mismatch_count_o,
    output logic                    err_sticky_o,
    output logic [1:0]              state_o
`ifdef POP_MON_MINMAX_EN
    ,
    output logic [7:0]              min_val_o,
    output logic [7:0]              max_val_o
`endif
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [1:0] {StIdle = 2'b00, StRun = 2'b01, StFrozen = 2'b10} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic              overflow_q, overflow_d, err_q, err_d;
    logic [CntW-1:0]   pop_cnt_q, pop_cnt_d, mis_cnt_q, mis_cnt_d;
    logic [7:0]        mem_q [Depth];

    logic accept, mismatch, full, empty, rd_en, wr_en, drop, wr_fire;

    always_comb begin
        accept   = (state_q == StRun) && bus.pop_valid;
        mismatch = accept && (bus.pop_data != ExpVal);
        full     = (level_q == LvlW'(Depth));
        empty    = (level_q == '0);
        rd_en    = !empty && bus.hist_ready;
        // A full FIFO still takes the write when the same cycle frees a slot.
        wr_en    = accept && (!full || rd_en);
        drop     = accept && full && !rd_en;
        wr_fire  = wr_en && !clear_i;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (enable_i) state_d = StRun;
            StRun: begin
                if (FreezeErr && mismatch) state_d = StFrozen;
                else if (!enable_i)        state_d = StIdle;
            end
            StFrozen: state_d = StFrozen;
            default:  state_d = StIdle;
        endcase
        if (clear_i) state_d = StIdle;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        err_d      = err_q;
        pop_cnt_d  = pop_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        if (clear_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            err_d      = 1'b0;
            pop_cnt_d  = '0;
            mis_cnt_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (wr_en && !rd_en)      level_d = level_q + LvlW'(1);
            else if (!wr_en && rd_en) level_d = level_q - LvlW'(1);
            if (drop) overflow_d = 1'b1;
            if (mismatch) err_d = 1'b1;
            if (accept && (pop_cnt_q != '1))   pop_cnt_d = pop_cnt_q + CntW'(1);
            if (mismatch && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
            pop_cnt_q  <= '0;
            mis_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
            pop_cnt_q  <= pop_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    // Storage needs no reset: hist_data is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_ptr_q] <= bus.pop_data;
    end

    assign bus.hist_valid   = !empty;
    assign bus.hist_data    = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign level_o          = level_q;
    assign full_o           = full;
    assign overflow_o       = overflow_q;
    assign pop_count_o      = pop_cnt_q;
    assign mismatch_count_o = mis_cnt_q;
    assign err_sticky_o     = err_q;
    assign state_o          = state_q;

`ifdef POP_MON_MINMAX_EN
    logic [7:0] min_q, min_d, max_q, max_d;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clear_i) begin
            min_d = 8'hFF;
            max_d = 8'h00;
        end else if (accept) begin
            if (bus.pop_data < min_q) min_d = bus.pop_data;
            if (bus.pop_data > max_q) max_d = bus.pop_data;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            min_q <= 8'hFF;
            max_q <= 8'h00;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_val_o = min_q;
    assign max_val_o = max_q;
`endif
endmodule

// File: tb/tb_pop_stream_monitor.sv
// Directed bench for pop_stream_monitor: table of single-cycle vectors plus multi-cycle sequences.
// dut1 uses the freezing default; dut2 has FreezeErr=0 for the wrap and min/max sequences.
module tb_pop_stream_monitor;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic        en1, clr1, en2, clr2;
    logic [4:0]  lvl1, lvl2;
    logic        full1, full2, ovf1, ovf2, err1, err2;
    logic [15:0] pc1, pc2, mc1, mc2;
    logic [1:0]  st1, st2;
`ifdef POP_MON_MINMAX_EN
    logic [7:0]  min1, max1, min2, max2;
`endif

    pop_stream_monitor_if bus1 ();
    pop_stream_monitor_if bus2 ();

    pop_stream_monitor #(.Depth(16), .ExpVal(8'h08), .CntW(16), .FreezeErr(1'b1)) dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(en1), .clear_i(clr1), .bus(bus1),
        .level_o(lvl1), .full_o(full1), .overflow_o(ovf1), .pop_count_o(pc1),
        .mismatch_count_o(mc1), .err_sticky_o(err1), .state_o(st1)
`ifdef POP_MON_MINMAX_EN
        , .min_val_o(min1), .max_val_o(max1)
`endif
    );

    pop_stream_monitor #(.Depth(16), .ExpVal(8'h08), .CntW(16), .FreezeErr(1'b0)) dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(en2), .clear_i(clr2), .bus(bus2),
        .level_o(lvl2), .full_o(full2), .overflow_o(ovf2), .pop_count_o(pc2),
        .mismatch_count_o(mc2), .err_sticky_o(err2), .state_o(st2)
`ifdef POP_MON_MINMAX_EN
        , .min_val_o(min2), .max_val_o(max2)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       en, clr, pv;
        logic [7:0] pd;
        logic       hr;
        logic [4:0] lvl;
        logic [15:0] pc, mc;
        logic       err;
        logic [1:0] st;
        logic       hv;
        logic [7:0] hd;
    } vec_t;

    function automatic vec_t mk(int en, int clr, int pv, int pd, int hr, int lvl, int pc,
                                int mc, int err, int st, int hv, int hd);
        vec_t v;
        v.en = 1'(en); v.clr = 1'(clr); v.pv = 1'(pv); v.pd = 8'(pd); v.hr = 1'(hr);
        v.lvl = 5'(lvl); v.pc = 16'(pc); v.mc = 16'(mc); v.err = 1'(err);
        v.st = 2'(st); v.hv = 1'(hv); v.hd = 8'(hd);
        return v;
    endfunction

    vec_t tbl [21];
    int   exp_idx;

    initial begin
        en1 = 0; clr1 = 0; en2 = 0; clr2 = 0;
        bus1.pop_valid = 0; bus1.pop_data = 0; bus1.hist_ready = 0;
        bus2.pop_valid = 0; bus2.pop_data = 0; bus2.hist_ready = 0;

        //            en clr pv pd    hr | lvl pc mc err st hv hd
        tbl[0]  = mk(1, 0, 0, 8'h00, 0,   0, 0, 0, 0, 1, 0, 8'h00);
        tbl[1]  = mk(1, 0, 1, 8'h08, 0,   1, 1, 0, 0, 1, 1, 8'h08);
        tbl[2]  = mk(1, 0, 1, 8'h08, 0,   2, 2, 0, 0, 1, 1, 8'h08);
        tbl[3]  = mk(1, 0, 1, 8'h08, 0,   3, 3, 0, 0, 1, 1, 8'h08);
        tbl[4]  = mk(1, 0, 1, 8'h08, 0,   4, 4, 0, 0, 1, 1, 8'h08);
        tbl[5]  = mk(1, 0, 0, 8'h00, 1,   3, 4, 0, 0, 1, 1, 8'h08);
        tbl[6]  = mk(1, 0, 0, 8'h00, 1,   2, 4, 0, 0, 1, 1, 8'h08);
        tbl[7]  = mk(1, 0, 0, 8'h00, 1,   1, 4, 0, 0, 1, 1, 8'h08);
        tbl[8]  = mk(1, 0, 0, 8'h00, 1,   0, 4, 0, 0, 1, 0, 8'h00);
        tbl[9]  = mk(1, 1, 0, 8'h00, 0,   0, 0, 0, 0, 0, 0, 8'h00);
        tbl[10] = mk(1, 0, 0, 8'h00, 0,   0, 0, 0, 0, 1, 0, 8'h00);
        tbl[11] = mk(1, 0, 1, 8'h08, 0,   1, 1, 0, 0, 1, 1, 8'h08);
        tbl[12] = mk(1, 0, 1, 8'h08, 0,   2, 2, 0, 0, 1, 1, 8'h08);
        tbl[13] = mk(1, 0, 1, 8'h3C, 0,   3, 3, 1, 1, 2, 1, 8'h08);
        tbl[14] = mk(1, 0, 1, 8'h08, 0,   3, 3, 1, 1, 2, 1, 8'h08);
        tbl[15] = mk(0, 0, 0, 8'h00, 1,   2, 3, 1, 1, 2, 1, 8'h08);
        tbl[16] = mk(0, 1, 0, 8'h00, 0,   0, 0, 0, 0, 0, 0, 8'h00);
        tbl[17] = mk(0, 0, 1, 8'h08, 0,   0, 0, 0, 0, 0, 0, 8'h00);
        tbl[18] = mk(1, 0, 1, 8'h55, 0,   0, 0, 0, 0, 1, 0, 8'h00);
        tbl[19] = mk(0, 0, 1, 8'h08, 0,   1, 1, 0, 0, 0, 1, 8'h08);
        tbl[20] = mk(0, 0, 0, 8'h00, 1,   0, 1, 0, 0, 0, 0, 8'h00);

        tick();
        chk("rst_level", 32'(lvl1), 0);
        chk("rst_state", 32'(st1), 0);
        chk("rst_hvalid", 32'(bus1.hist_valid), 0);
`ifdef POP_MON_MINMAX_EN
        chk("rst_min", 32'(min2), 32'hFF);
        chk("rst_max", 32'(max2), 0);
`endif
        rst_ni = 1'b1;
        tick();

        // Single-cycle vectors: normal capture/drain, freeze on mismatch, clear, IDLE gating.
        for (int i = 0; i < 21; i++) begin
            en1 = tbl[i].en; clr1 = tbl[i].clr; bus1.pop_valid = tbl[i].pv;
            bus1.pop_data = tbl[i].pd; bus1.hist_ready = tbl[i].hr;
            tick();
            chk($sformatf("v%0d_level", i), 32'(lvl1), 32'(tbl[i].lvl));
            chk($sformatf("v%0d_popcnt", i), 32'(pc1), 32'(tbl[i].pc));
            chk($sformatf("v%0d_miscnt", i), 32'(mc1), 32'(tbl[i].mc));
            chk($sformatf("v%0d_err", i), 32'(err1), 32'(tbl[i].err));
            chk($sformatf("v%0d_state", i), 32'(st1), 32'(tbl[i].st));
            chk($sformatf("v%0d_hvalid", i), 32'(bus1.hist_valid), 32'(tbl[i].hv));
            chk($sformatf("v%0d_hdata", i), 32'(bus1.hist_data), 32'(tbl[i].hd));
            chk($sformatf("v%0d_ovf", i), 32'(ovf1), 0);
        end
        bus1.pop_valid = 0; bus1.hist_ready = 0;

        // Full FIFO: 17th pop dropped with no read.
        en1 = 1; clr1 = 1; tick();
        clr1 = 0; tick();
        bus1.pop_data = 8'h08;
        for (int i = 0; i < 17; i++) begin
            bus1.pop_valid = 1; tick();
        end
        bus1.pop_valid = 0;
        chk("full_level", 32'(lvl1), 16);
        chk("full_flag", 32'(full1), 1);
        chk("full_ovf", 32'(ovf1), 1);
        chk("full_popcnt", 32'(pc1), 17);
        clr1 = 1; tick();
        clr1 = 0;
        chk("clr_ovf", 32'(ovf1), 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            bus1.pop_valid = 1; tick();
        end
        bus1.hist_ready = 1; tick();
        bus1.pop_valid = 0; bus1.hist_ready = 0;
        chk("fullrw_level", 32'(lvl1), 16);
        chk("fullrw_ovf", 32'(ovf1), 0);
        chk("fullrw_full", 32'(full1), 1);
        chk("fullrw_popcnt", 32'(pc1), 17);

        // Pointer wrap on the non-freezing instance, reads interleaved with writes.
        clr2 = 1; tick();
        clr2 = 0; en2 = 1; tick();
        exp_idx = 0;
        for (int i = 0; i < 40; i++) begin
            bus2.pop_valid = 1; bus2.pop_data = 8'(i);
            bus2.hist_ready = (i % 3 != 1);
            if (bus2.hist_valid && bus2.hist_ready) begin
                chk("wrap_data", 32'(bus2.hist_data), 32'(exp_idx));
                exp_idx++;
            end
            tick();
        end
        bus2.pop_valid = 0; bus2.hist_ready = 1;
        for (int k = 0; k < 100 && exp_idx < 40; k++) begin
            if (bus2.hist_valid) begin
                chk("wrap_data", 32'(bus2.hist_data), 32'(exp_idx));
                exp_idx++;
            end
            tick();
        end
        bus2.hist_ready = 0;
        chk("wrap_count", 32'(exp_idx), 40);
        chk("wrap_level", 32'(lvl2), 0);
        chk("wrap_popcnt", 32'(pc2), 40);
        chk("wrap_miscnt", 32'(mc2), 39);
        chk("wrap_state", 32'(st2), 1);
        chk("wrap_ovf", 32'(ovf2), 0);

`ifdef POP_MON_MINMAX_EN
        clr2 = 1; tick();
        clr2 = 0; tick();
        foreach (tbl[j]) begin end
        bus2.pop_valid = 1;
        bus2.pop_data = 8'h08; tick();
        bus2.pop_data = 8'h02; tick();
        bus2.pop_data = 8'hF0; tick();
        bus2.pop_valid = 0;
        chk("mm_min", 32'(min2), 32'h02);
        chk("mm_max", 32'(max2), 32'hF0);
        clr2 = 1; tick();
        clr2 = 0;
        chk("mm_clr_min", 32'(min2), 32'hFF);
        chk("mm_clr_max", 32'(max2), 0);
`endif

        // Asynchronous reset mid-RUN with a partly filled FIFO.
        clr1 = 1; tick();
        clr1 = 0; en1 = 1; tick();
        bus1.pop_data = 8'h08;
        for (int i = 0; i < 5; i++) begin
            bus1.pop_valid = 1; tick();
        end
        bus1.pop_valid = 0;
        chk("pre_rst_level", 32'(lvl1), 5);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_level", 32'(lvl1), 0);
        chk("arst_popcnt", 32'(pc1), 0);
        chk("arst_state", 32'(st1), 0);
        chk("arst_hvalid", 32'(bus1.hist_valid), 0);
        chk("arst_hdata", 32'(bus1.hist_data), 0);
        chk("arst_full", 32'(full1), 0);
        en1 = 0;
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_rst_state", 32'(st1), 0);
        chk("post_rst_level", 32'(lvl1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
